ovi_issue_scheduler: RTL and testbench
======================================

// Module: ovi_issue_scheduler
// PURPOSE
// - Sits between the core automata and the VPU, inside the OVI path. Buffers core vector issues and releases them only while VPU issue credits and free scoreboard IDs are available.
// - Tags each issue with a scoreboard ID (sb_id) and routes VPU completions back to the core by sb_id.
// - Replaces the ad-hoc "credit = completed.valid" tie-off in the top level.
// PARAMETERS
// QDEPTH   4   issue-queue entries (power of 2, >=2)
// CREDITS  4   VPU issue credits held after reset (>=1)
// NUM_SB   8   scoreboard IDs in flight (power of 2); SBW = $clog2(NUM_SB)
// PORTS
// CLK                  in   1    clock
// RESET                in   1    synchronous, active-high reset
// CORE_ISSUE_VALID     in   1    core presents instruction; accepted when VALID && CORE_ISSUE_READY
// CORE_ISSUE_INST      in   32   vector instruction
// CORE_ISSUE_SCALAR    in   64   scalar operand
// CORE_ISSUE_READY     out  1    queue can accept this cycle
// CORE_HALT            in   1    stop accepting new issues; in-flight work drains
// VPU_ISSUE_VALID      out  1    one-cycle pulse per issued instruction
// VPU_ISSUE_INST       out  32   instruction of the issued entry
// VPU_ISSUE_SCALAR     out  64   scalar of the issued entry
// VPU_ISSUE_SB_ID      out  SBW  sb_id assigned to the issued entry
// ISSUE_CREDIT         in   1    VPU returns one credit (pulse)
// VPU_COMPLETED_VALID  in   1    VPU completed one instruction
// VPU_COMPLETED_SB_ID  in   SBW  sb_id of the completed instruction
// CORE_COMPLETED_VALID out  1    completion forwarded to core (pulse)
// CORE_COMPLETED_SB_ID out  SBW  sb_id forwarded
// IDLE                 out  1    queue empty, no sb_id busy, credits == CREDITS
// ERR                  out  2    sticky: [0] credit overflow, [1] completion of non-busy sb_id
// BEHAVIOUR
// - Reset: queue empty; credits = CREDITS; sb_busy = 0; all VALID outs 0; data and sb_id outs 0; ERR = 0; IDLE = 1; CORE_ISSUE_READY = 1 in the cycle after reset deasserts.
// - RESET asserted mid-operation: queued entries and busy IDs are discarded; no pulse in the following cycle; same state as power-up reset.
// - Accept: CORE_ISSUE_READY = !full && !CORE_HALT, from registered state only.
//   - At full, READY is 0 even if a dequeue happens the same cycle.
//   - CORE_HALT masks READY combinationally; already queued entries still issue.
// - Issue condition, evaluated on registered state: queue non-empty && credits > 0 && any sb_busy bit clear.
//   - When it holds: the head is dequeued. VPU_ISSUE_* are registered and pulse the next cycle.
//   - The lowest-index free sb_id is assigned and set busy; credits decrement.
//   - At most one issue per cycle.
// - Latency: entry accepted at edge N reaches VPU_ISSUE_VALID at N+1 at the earliest (queue empty, resources free). Issues are in strict FIFO order.
// - Credits, width $clog2(CREDITS+1):
//   - Issue and ISSUE_CREDIT in the same cycle: count unchanged.
//   - ISSUE_CREDIT at credits == CREDITS with no issue: ignored, ERR[0] set.
//   - credits == 0: issue stalls and the queue holds.
// - Completion:
//   - VPU_COMPLETED_VALID with a busy sb_id: clears the bit; CORE_COMPLETED_VALID/SB_ID pulse the next cycle.
//   - Non-busy sb_id: no forward, no state change, ERR[1] set.
//   - An sb_id freed at edge N is allocatable from the issue decision at N+1, never the same cycle.
// - Simultaneous accept + issue + credit + completion in one cycle: all take effect independently. Occupancy and count updates are net.
// - Queue pointers: log2(QDEPTH)+1 bits, wrap naturally; full/empty from the MSB compare.
// - IDLE is registered.
// TESTING
// - Single issue, CREDITS=4: accept INST=0x57 at cycle 10 -> VPU_ISSUE_VALID at 11, SB_ID=0, credits=3; complete sb 0 -> CORE_COMPLETED_VALID sb 0 one cycle later.
// - Credit exhaustion: 6 back-to-back issues, no ISSUE_CREDIT -> exactly 4 VPU pulses (sb 0..3); READY drops when the queue reaches 4 (2 queued + in-flight pattern); one ISSUE_CREDIT -> 5th issues the next cycle with sb 4.
// - Same-cycle issue + ISSUE_CREDIT at credits=1 -> credits stays 1; extra ISSUE_CREDIT at credits=4 -> ERR[0]=1, credits=4.
// - NUM_SB exhaustion: 8 issues with credits recycled, no completion -> 9th waits; complete sb 3 -> 9th issues with SB_ID=3 two cycles after the completion.
// - Bogus completion of idle sb 5 -> no CORE_COMPLETED_VALID, ERR[1]=1; CORE_HALT during a queue of 3 -> READY=0, all 3 still issue, IDLE=1 after all complete and credits return.
// - RESET with 2 queued and 2 busy -> next cycle IDLE=1, no VPU or core pulses, ERR=0.

Source files
------------

// File: rtl/ovi_issue_scheduler_if.sv
// Handshake bundle between the core automata, the issue scheduler and the VPU.
// The master side is the core/VPU environment and the slave side is the scheduler.
interface ovi_issue_scheduler_if #(
   parameter int SBW = 3
);
   logic           coreIssueValid;
   logic [31:0]    coreIssueInst;
   logic [63:0]    coreIssueScalar;
   logic           coreIssueReady;
   logic           vpuIssueValid;
   logic [31:0]    vpuIssueInst;
   logic [63:0]    vpuIssueScalar;
   logic [SBW-1:0] vpuIssueSbId;
   logic           issueCredit;
   logic           vpuCompletedValid;
   logic [SBW-1:0] vpuCompletedSbId;
   logic           coreCompletedValid;
   logic [SBW-1:0] coreCompletedSbId;

   modport master (
      output coreIssueValid, coreIssueInst, coreIssueScalar,
      input  coreIssueReady,
      input  vpuIssueValid, vpuIssueInst, vpuIssueScalar, vpuIssueSbId,
      output issueCredit, vpuCompletedValid, vpuCompletedSbId,
      input  coreCompletedValid, coreCompletedSbId
   );

   modport slave (
      input  coreIssueValid, coreIssueInst, coreIssueScalar,
      output coreIssueReady,
      output vpuIssueValid, vpuIssueInst, vpuIssueScalar, vpuIssueSbId,
      input  issueCredit, vpuCompletedValid, vpuCompletedSbId,
      output coreCompletedValid, coreCompletedSbId
   );
endinterface

// File: rtl/ovi_issue_scheduler.sv
// OVI issue scheduler: buffers core vector issues and releases them to the VPU only
// while issue credits and free scoreboard IDs exist, then routes completions back by sb_id.
module ovi_issue_scheduler #(
   parameter int QDEPTH  = 4,
   parameter int CREDITS = 4,
   parameter int NUM_SB  = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_coreHalt,
   output logic                 o_idle,
   output logic [1:0]           o_err,
   ovi_issue_scheduler_if.slave bus
);
   localparam int SBW = $clog2(NUM_SB);
   localparam int QW  = $clog2(QDEPTH);
   localparam int CW  = $clog2(CREDITS + 1);
   localparam logic [QW:0]   PTR_ONE  = 1;
   localparam logic [CW-1:0] CRED_ONE = 1;
   localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

   logic [31:0]       r_qInst   [QDEPTH];
   logic [63:0]       r_qScalar [QDEPTH];
   logic [QW:0]       r_wrPtr;
   logic [QW:0]       r_rdPtr;
   logic [CW-1:0]     r_credits;
   logic [NUM_SB-1:0] r_sbBusy;
   logic              r_vpuIssueValid;
   logic [31:0]       r_vpuIssueInst;
   logic [63:0]       r_vpuIssueScalar;
   logic [SBW-1:0]    r_vpuIssueSbId;
   logic              r_coreCompletedValid;
   logic [SBW-1:0]    r_coreCompletedSbId;
   logic              r_idle;
   logic [1:0]        r_err;

   logic              w_empty;
   logic              w_full;
   logic              w_ready;
   logic              w_accept;
   logic              w_issue;
   logic              w_complOk;
   logic              w_complBad;
   logic              w_creditOverflow;
   logic [SBW-1:0]    w_freeId;
   logic [QW:0]       w_wrPtrNext;
   logic [QW:0]       w_rdPtrNext;
   logic [CW-1:0]     w_creditsNext;
   logic [NUM_SB-1:0] w_sbBusyNext;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign w_empty  = (r_wrPtr == r_rdPtr);
   assign w_full   = (r_wrPtr[QW] != r_rdPtr[QW]) && (r_wrPtr[QW-1:0] == r_rdPtr[QW-1:0]);
   assign w_ready  = !w_full && !i_coreHalt;
   assign w_accept = bus.coreIssueValid && w_ready;

   assign w_issue          = !w_empty && (r_credits != '0) && !(&r_sbBusy);
   assign w_complOk        = bus.vpuCompletedValid && r_sbBusy[bus.vpuCompletedSbId];
   assign w_complBad       = bus.vpuCompletedValid && !r_sbBusy[bus.vpuCompletedSbId];
   assign w_creditOverflow = bus.issueCredit && !w_issue && (r_credits == CRED_MAX);

   assign w_wrPtrNext = w_accept ? (r_wrPtr + PTR_ONE) : r_wrPtr;
   assign w_rdPtrNext = w_issue  ? (r_rdPtr + PTR_ONE) : r_rdPtr;

   // Priority search from the top so the lowest clear index wins.
   always_comb begin
      w_freeId = '0;
      for (int i = NUM_SB - 1; i >= 0; i--) begin
         if (!r_sbBusy[i]) begin
            w_freeId = SBW'(i);
         end
      end
   end

   // A same-cycle issue and returned credit cancel, leaving the count unchanged.
   always_comb begin
      w_creditsNext = r_credits;
      if (w_issue && !bus.issueCredit) begin
         w_creditsNext = r_credits - CRED_ONE;
      end else if (!w_issue && bus.issueCredit && !w_creditOverflow) begin
         w_creditsNext = r_credits + CRED_ONE;
      end
   end

   // A completing ID is busy and the allocated ID is free, so the two never collide.
   always_comb begin
      w_sbBusyNext = r_sbBusy;
      if (w_complOk) begin
         w_sbBusyNext[bus.vpuCompletedSbId] = 1'b0;
      end
      if (w_issue) begin
         w_sbBusyNext[w_freeId] = 1'b1;
      end
   end

   // Queue storage holds payload only; validity lives in the pointers.
   always_ff @(posedge i_clk) begin
      if (w_accept) begin
         r_qInst[r_wrPtr[QW-1:0]]   <= bus.coreIssueInst;
         r_qScalar[r_wrPtr[QW-1:0]] <= bus.coreIssueScalar;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wrPtr              <= '0;
         r_rdPtr              <= '0;
         r_credits            <= CRED_MAX;
         r_sbBusy             <= '0;
         r_vpuIssueValid      <= 1'b0;
         r_vpuIssueInst       <= '0;
         r_vpuIssueScalar     <= '0;
         r_vpuIssueSbId       <= '0;
         r_coreCompletedValid <= 1'b0;
         r_coreCompletedSbId  <= '0;
         r_idle               <= 1'b1;
         r_err                <= '0;
      end else begin
         r_wrPtr              <= w_wrPtrNext;
         r_rdPtr              <= w_rdPtrNext;
         r_credits            <= w_creditsNext;
         r_sbBusy             <= w_sbBusyNext;
         r_vpuIssueValid      <= w_issue;
         if (w_issue) begin
            r_vpuIssueInst   <= r_qInst[r_rdPtr[QW-1:0]];
            r_vpuIssueScalar <= r_qScalar[r_rdPtr[QW-1:0]];
            r_vpuIssueSbId   <= w_freeId;
         end
         r_coreCompletedValid <= w_complOk;
         if (w_complOk) begin
            r_coreCompletedSbId <= bus.vpuCompletedSbId;
         end
         // Idle reflects the state being entered, so it never lags the scheduler.
         r_idle <= (w_wrPtrNext == w_rdPtrNext) && (w_sbBusyNext == '0) &&
                   (w_creditsNext == CRED_MAX);
         r_err  <= r_err | {w_complBad, w_creditOverflow};
      end
   end

   assign bus.coreIssueReady     = w_ready;
   assign bus.vpuIssueValid      = r_vpuIssueValid;
   assign bus.vpuIssueInst       = r_vpuIssueInst;
   assign bus.vpuIssueScalar     = r_vpuIssueScalar;
   assign bus.vpuIssueSbId       = r_vpuIssueSbId;
   assign bus.coreCompletedValid = r_coreCompletedValid;
   assign bus.coreCompletedSbId  = r_coreCompletedSbId;
   assign o_idle                 = r_idle;
   assign o_err                  = r_err;
endmodule

// File: tb/tb_ovi_issue_scheduler.sv
// Self-checking bench for ovi_issue_scheduler: directed scenarios plus randomized traffic,
// all compared every cycle against a queue-based reference model.
module tb_ovi_issue_scheduler;
   localparam int QDEPTH  = 4;
   localparam int CREDITS = 4;
   localparam int NUM_SB  = 8;
   localparam int SBW     = 3;

   typedef struct packed {
      logic [31:0] inst;
      logic [63:0] scalar;
   } entry_t;

   logic       clk  = 1'b0;
   logic       rst  = 1'b1;
   logic       halt = 1'b0;
   logic       idle;
   logic [1:0] err;
   int         checks = 0;
   int         passed = 0;

   ovi_issue_scheduler_if #(.SBW(SBW)) bus ();

   ovi_issue_scheduler #(.QDEPTH(QDEPTH), .CREDITS(CREDITS), .NUM_SB(NUM_SB)) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_coreHalt (halt),
      .o_idle     (idle),
      .o_err      (err),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   // Reference model state: what has been accepted, what is outstanding, what is owed.
   entry_t            mq[$];
   int                mCredits = CREDITS;
   logic [NUM_SB-1:0] mBusy = '0;
   bit                modelValid = 0;
   bit                expIssueValid = 0;
   bit                expCompValid = 0;
   bit                expIdle = 1;
   logic [31:0]       expInst = '0;
   logic [63:0]       expScalar = '0;
   logic [SBW-1:0]    expSbId = '0;
   logic [SBW-1:0]    expCompSbId = '0;
   logic [1:0]        expErr = '0;
   int                pulseCount = 0;
   logic [SBW-1:0]    lastSbId = '0;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end else begin
         passed++;
      end
   endtask

   // Model update: each rule applied to the state as it was before this edge.
   bit                doAccept;
   bit                doIssue;
   bit                found;
   logic [NUM_SB-1:0] busyBefore;
   int                creditsBefore;
   entry_t            e;
   always @(posedge clk) begin
      if (rst) begin
         mq.delete();
         mCredits      = CREDITS;
         mBusy         = '0;
         expIssueValid = 0;
         expCompValid  = 0;
         expErr        = '0;
         expIdle       = 1;
         modelValid    = 1;
      end else begin
         doAccept      = (mq.size() < QDEPTH) && !halt && (bus.coreIssueValid === 1'b1);
         doIssue       = (mq.size() > 0) && (mCredits > 0) && ($countones(mBusy) < NUM_SB);
         busyBefore    = mBusy;
         creditsBefore = mCredits;
         expIssueValid = 0;
         expCompValid  = 0;
         if (doIssue) begin
            e     = mq.pop_front();
            found = 0;
            for (int i = 0; i < NUM_SB; i++) begin
               if (!found && !busyBefore[i]) begin
                  expSbId = SBW'(i);
                  found   = 1;
               end
            end
            mBusy[expSbId] = 1'b1;
            mCredits       = mCredits - 1;
            expIssueValid  = 1;
            expInst        = e.inst;
            expScalar      = e.scalar;
         end
         if (bus.issueCredit) begin
            if (!doIssue && creditsBefore == CREDITS) expErr[0] = 1'b1;
            else mCredits = mCredits + 1;
         end
         if (bus.vpuCompletedValid) begin
            if (busyBefore[bus.vpuCompletedSbId]) begin
               mBusy[bus.vpuCompletedSbId] = 1'b0;
               expCompValid = 1;
               expCompSbId  = bus.vpuCompletedSbId;
            end else begin
               expErr[1] = 1'b1;
            end
         end
         if (doAccept) mq.push_back('{inst: bus.coreIssueInst, scalar: bus.coreIssueScalar});
         expIdle = (mq.size() == 0) && (mBusy == '0) && (mCredits == CREDITS);
      end
   end

   // Compare process, away from the active edge.
   always @(negedge clk) begin
      if (modelValid) begin
         checkOutput("ready", bus.coreIssueReady, (mq.size() < QDEPTH) && !halt);
         checkOutput("vpuIssueValid", bus.vpuIssueValid, expIssueValid);
         if (expIssueValid) begin
            checkOutput("vpuIssueInst", bus.vpuIssueInst, expInst);
            checkOutput("vpuIssueScalar", bus.vpuIssueScalar, expScalar);
            checkOutput("vpuIssueSbId", bus.vpuIssueSbId, expSbId);
         end
         checkOutput("coreCompletedValid", bus.coreCompletedValid, expCompValid);
         if (expCompValid) checkOutput("coreCompletedSbId", bus.coreCompletedSbId, expCompSbId);
         checkOutput("idle", idle, expIdle);
         checkOutput("err", err, expErr);
      end
      if (bus.vpuIssueValid === 1'b1) begin
         pulseCount++;
         lastSbId = bus.vpuIssueSbId;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   // Presents one instruction and holds it until the scheduler takes it.
   task automatic applyStimulus(input logic [31:0] inst, input logic [63:0] scalar);
      int guard;
      guard = 0;
      bus.coreIssueInst   = inst;
      bus.coreIssueScalar = scalar;
      bus.coreIssueValid  = 1'b1;
      while (bus.coreIssueReady !== 1'b1 && guard < 50) begin
         step();
         guard++;
      end
      checkOutput("acceptWait", guard < 50, 1);
      step();
      bus.coreIssueValid = 1'b0;
   endtask

   task automatic creditPulse();
      bus.issueCredit = 1'b1;
      step();
      bus.issueCredit = 1'b0;
   endtask

   task automatic completePulse(input logic [SBW-1:0] id);
      bus.vpuCompletedValid = 1'b1;
      bus.vpuCompletedSbId  = id;
      step();
      bus.vpuCompletedValid = 1'b0;
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, checks);
      $fatal(1, "[TB] watchdog");
   end

   logic [SBW-1:0] idc;
   initial begin
      bus.coreIssueValid    = 1'b0;
      bus.coreIssueInst     = '0;
      bus.coreIssueScalar   = '0;
      bus.issueCredit       = 1'b0;
      bus.vpuCompletedValid = 1'b0;
      bus.vpuCompletedSbId  = '0;

      // Reset state and a single issue/complete round trip.
      doReset();
      checkOutput("rstIdle", idle, 1);
      checkOutput("rstReady", bus.coreIssueReady, 1);
      checkOutput("rstErr", err, 0);
      checkOutput("rstVpuValid", bus.vpuIssueValid, 0);
      checkOutput("rstVpuSbId", bus.vpuIssueSbId, 0);
      checkOutput("rstVpuInst", bus.vpuIssueInst, 0);
      applyStimulus(32'h57, 64'h1234);
      checkOutput("s1NoEarlyIssue", bus.vpuIssueValid, 0);
      step();
      checkOutput("s1IssueValid", bus.vpuIssueValid, 1);
      checkOutput("s1IssueInst", bus.vpuIssueInst, 32'h57);
      checkOutput("s1IssueSbId", bus.vpuIssueSbId, 0);
      checkOutput("s1Credits", mCredits, 3);
      completePulse(0);
      checkOutput("s1CompValid", bus.coreCompletedValid, 1);
      checkOutput("s1CompSbId", bus.coreCompletedSbId, 0);
      creditPulse();
      checkOutput("s1Idle", idle, 1);

      // Credit exhaustion.
      doReset();
      pulseCount = 0;
      for (int i = 0; i < 6; i++) applyStimulus(32'h100 + i, 64'(i));
      step(); step(); step();
      checkOutput("s2PulseCount", pulseCount, 4);
      checkOutput("s2LastSbId", lastSbId, 3);
      checkOutput("s2Credits", mCredits, 0);
      applyStimulus(32'h106, 64'h6);
      applyStimulus(32'h107, 64'h7);
      checkOutput("s2ReadyFull", bus.coreIssueReady, 0);
      creditPulse();
      checkOutput("s2NoIssueYet", bus.vpuIssueValid, 0);
      step();
      checkOutput("s2FifthValid", bus.vpuIssueValid, 1);
      checkOutput("s2FifthSbId", bus.vpuIssueSbId, 4);
      checkOutput("s2FifthInst", bus.vpuIssueInst, 32'h104);

      // Same-cycle issue and credit, then credit overflow.
      doReset();
      for (int i = 0; i < 3; i++) applyStimulus(32'h300 + i, 64'(i));
      step();
      applyStimulus(32'h303, 64'h3);
      bus.issueCredit = 1'b1;
      step();
      bus.issueCredit = 1'b0;
      checkOutput("s3IssueValid", bus.vpuIssueValid, 1);
      checkOutput("s3IssueSbId", bus.vpuIssueSbId, 3);
      checkOutput("s3CreditsNet", mCredits, 1);
      creditPulse(); creditPulse(); creditPulse();
      checkOutput("s3CreditsFull", mCredits, 4);
      checkOutput("s3ErrClear", err, 0);
      creditPulse();
      checkOutput("s3ErrOverflow", err, 1);
      checkOutput("s3CreditsHeld", mCredits, 4);

      // Scoreboard exhaustion and reuse of a freed ID.
      doReset();
      pulseCount = 0;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(32'h200 + i, 64'(i));
         step();
         creditPulse();
      end
      applyStimulus(32'h2FF, 64'hFF);
      step(); step(); step();
      checkOutput("s4PulseCount", pulseCount, 8);
      completePulse(3);
      checkOutput("s4CompValid", bus.coreCompletedValid, 1);
      checkOutput("s4CompSbId", bus.coreCompletedSbId, 3);
      checkOutput("s4NotSameCycle", bus.vpuIssueValid, 0);
      step();
      checkOutput("s4NinthValid", bus.vpuIssueValid, 1);
      checkOutput("s4NinthSbId", bus.vpuIssueSbId, 3);
      checkOutput("s4NinthInst", bus.vpuIssueInst, 32'h2FF);

      // Bogus completion, then halt with three queued entries.
      doReset();
      completePulse(5);
      checkOutput("s5NoForward", bus.coreCompletedValid, 0);
      checkOutput("s5ErrBogus", err, 2);
      for (int i = 0; i < 7; i++) applyStimulus(32'h500 + i, 64'(i));
      step(); step();
      halt = 1'b1;
      #1;
      checkOutput("s5HaltReady", bus.coreIssueReady, 0);
      pulseCount = 0;
      creditPulse(); creditPulse(); creditPulse();
      step(); step(); step();
      checkOutput("s5HaltDrain", pulseCount, 3);
      halt = 1'b0;
      for (int i = 0; i < 7; i++) completePulse(SBW'(i));
      creditPulse(); creditPulse(); creditPulse(); creditPulse();
      checkOutput("s5IdleAfter", idle, 1);

      // Reset in the middle of traffic.
      doReset();
      for (int i = 0; i < 6; i++) applyStimulus(32'h600 + i, 64'(i));
      step(); step();
      checkOutput("s6NotIdle", idle, 0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      checkOutput("s6Idle", idle, 1);
      checkOutput("s6VpuValid", bus.vpuIssueValid, 0);
      checkOutput("s6CompValid", bus.coreCompletedValid, 0);
      checkOutput("s6Err", err, 0);
      step();
      checkOutput("s6VpuValidAfter", bus.vpuIssueValid, 0);
      checkOutput("s6IdleAfter", idle, 1);

      // Randomized traffic, checked by the compare process every cycle.
      for (int c = 0; c < 3000; c++) begin
         bus.coreIssueValid    = 1'($urandom_range(0, 1));
         bus.coreIssueInst     = $urandom;
         bus.coreIssueScalar   = {$urandom, $urandom};
         halt                  = ($urandom_range(0, 9) == 0);
         bus.issueCredit       = (mCredits < CREDITS && $urandom_range(0, 2) == 0) ||
                                 ($urandom_range(0, 199) == 0);
         bus.vpuCompletedValid = 1'b0;
         if ($urandom_range(0, 2) == 0) begin
            idc = SBW'($urandom_range(0, NUM_SB - 1));
            if (mBusy[idc] || $urandom_range(0, 49) == 0) begin
               bus.vpuCompletedValid = 1'b1;
               bus.vpuCompletedSbId  = idc;
            end
         end
         rst = ($urandom_range(0, 599) == 0);
         step();
      end
      bus.coreIssueValid    = 1'b0;
      bus.issueCredit       = 1'b0;
      bus.vpuCompletedValid = 1'b0;
      halt                  = 1'b0;
      rst                   = 1'b0;
      step(); step();

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
